// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the EX-stage iterative divider controller:
//   - default operand width and iteration counter width
//   - 3-bit state encodings of the divider sequencer
//   - start/stop strobe levels used on the EX -> divider control bus
//   - width of the EX -> divider control bus (start, signed_op, op_a, op_b)
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

   // Operand/result width and iteration counter width (2**DIV_CNT_W > DIV_WIDTH).
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   // Sequencer states. The encodings are fixed so that the state can be
   // observed on debug buses with a stable meaning.
   typedef enum logic [2:0] {
      DIV_IDLE = 3'd0,
      DIV_PREP = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      DIV_DONE = 3'd4
   } div_state_e;

   // Strobe levels on the start line coming from EX.
   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // EX -> divider control bus: start, signed_op, op_a, op_b.
   localparam int DIV_CTRL_BUS_W = 2 + (2 * DIV_WIDTH);

endpackage : div_ctrl_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// The dividend is held in quot_part and shifted out MSB-first into the partial
// remainder while the new quotient bit is shifted in at the LSB.
// Ports:
//   rem_part       in   WIDTH  current partial remainder (always < divisor)
//   quot_part      in   WIDTH  remaining dividend bits / quotient bits so far
//   divisor        in   WIDTH  divisor magnitude (non-zero while stepping)
//   rem_part_nxt   out  WIDTH  partial remainder after this step
//   quot_part_nxt  out  WIDTH  quotient/dividend register after this step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_part,
   input  logic [WIDTH-1:0] quot_part,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_part_nxt,
   output logic [WIDTH-1:0] quot_part_nxt
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] trial_s;
   logic           borrow_s;

   // Shift in the next dividend bit and try subtracting the divisor.
   // shifted_s < 2*divisor and divisor < 2**WIDTH, so the (WIDTH+1)-bit
   // difference has its MSB set exactly when the subtraction borrows.
   always_comb begin
      shifted_s = {rem_part, quot_part[WIDTH-1]};
      trial_s   = shifted_s - {1'b0, divisor};
      borrow_s  = trial_s[WIDTH];
   end

   // Restore on borrow, otherwise keep the difference and set the quotient bit.
   always_comb begin
      if (borrow_s) begin
         rem_part_nxt  = shifted_s[WIDTH-1:0];
         quot_part_nxt = {quot_part[WIDTH-2:0], 1'b0};
      end else begin
         rem_part_nxt  = trial_s[WIDTH-1:0];
         quot_part_nxt = {quot_part[WIDTH-2:0], 1'b1};
      end
   end

endmodule : div_step

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencer for the shared iterative radix-2 divider serving DIV/DIVU in EX.
// Operands are latched in IDLE, converted to magnitudes in PREP, divided one
// restoring step per cycle in RUN, sign-corrected in FIX and presented with a
// one-cycle done pulse in DONE. stallreq holds IF..EX while a division is in
// flight and is the EX-stage stall source for the pipeline stall controller.
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      EX holds a DIV/DIVU (level, sampled only in IDLE)
//   signed_op  in   1      1 = DIV (two's complement), 0 = DIVU
//   flush      in   1      abort current operation, wins over start
//   op_a       in   WIDTH  dividend (rs)
//   op_b       in   WIDTH  divisor (rt)
//   stallreq   out  1      hold IF..EX while the division is in flight
//   busy       out  1      sequencer not in IDLE
//   done       out  1      one-cycle pulse: write HI <= rem, LO <= quot
//   quot       out  WIDTH  quotient, held until the next result
//   rem        out  WIDTH  remainder, held until the next result
// Latency: start seen in cycle 0 -> done in cycle WIDTH+3; divide by zero
// skips RUN and completes in cycle 3 with quot = all ones, rem = op_a.
// -----------------------------------------------------------------------------
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             stallreq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

   // Two's complement negation modulo 2**WIDTH.
   function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
      return (~v) + W_ONE;
   endfunction

   div_state_e        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              sgn_r;       // signed_op captured with start
   logic [WIDTH-1:0]  q_work_r;    // dividend, then quotient being built
   logic [WIDTH-1:0] r_work_r;     // partial remainder
   logic [WIDTH-1:0] div_work_r;   // divisor, then divisor magnitude
   logic              q_neg_r;     // quotient needs negation in FIX
   logic              r_neg_r;     // remainder needs negation in FIX
   logic              busy_r;
   logic              done_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;

   logic              a_neg_s;
   logic              b_neg_s;
   logic [WIDTH-1:0] a_abs_s;
   logic [WIDTH-1:0] b_abs_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_quot_s;
   logic              stall_s;

   // Magnitudes of the latched operands; only meaningful in PREP.
   // 0x80000000 stays 0x80000000, which is the correct unsigned magnitude.
   always_comb begin
      a_neg_s = sgn_r & q_work_r[WIDTH-1];
      b_neg_s = sgn_r & div_work_r[WIDTH-1];
      if (a_neg_s) begin
         a_abs_s = neg2c(q_work_r);
      end else begin
         a_abs_s = q_work_r;
      end
      if (b_neg_s) begin
         b_abs_s = neg2c(div_work_r);
      end else begin
         b_abs_s = div_work_r;
      end
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_part      (r_work_r),
      .quot_part     (q_work_r),
      .divisor       (div_work_r),
      .rem_part_nxt  (step_rem_s),
      .quot_part_nxt (step_quot_s)
   );

   // Sequencer: state, counter, working registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= DIV_IDLE;
         cnt_r      <= CNT_ZERO;
         sgn_r      <= 1'b0;
         q_work_r   <= W_ZERO;
         r_work_r   <= W_ZERO;
         div_work_r <= W_ZERO;
         q_neg_r    <= 1'b0;
         r_neg_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         quot_r     <= W_ZERO;
         rem_r      <= W_ZERO;
      end else if (flush) begin
         // Abort: results of the previous operation stay visible.
         state_r <= DIV_IDLE;
         cnt_r   <= CNT_ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               done_r <= 1'b0;
               if (start == DIV_START) begin
                  q_work_r   <= op_a;
                  div_work_r <= op_b;
                  sgn_r      <= signed_op;
                  state_r    <= DIV_PREP;
                  busy_r     <= 1'b1;
               end else begin
                  state_r <= DIV_IDLE;
                  busy_r  <= 1'b0;
               end
            end

            DIV_PREP: begin
               if (div_work_r == W_ZERO) begin
                  // Divide by zero: all-ones quotient, raw dividend as
                  // remainder, no sign correction.
                  q_work_r <= W_ONES;
                  r_work_r <= q_work_r;
                  q_neg_r  <= 1'b0;
                  r_neg_r  <= 1'b0;
                  state_r  <= DIV_FIX;
               end else begin
                  q_work_r   <= a_abs_s;
                  div_work_r <= b_abs_s;
                  r_work_r   <= W_ZERO;
                  q_neg_r    <= a_neg_s ^ b_neg_s;
                  r_neg_r    <= a_neg_s;
                  cnt_r      <= CNT_ZERO;
                  state_r    <= DIV_RUN;
               end
            end

            DIV_RUN: begin
               r_work_r <= step_rem_s;
               q_work_r <= step_quot_s;
               cnt_r    <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_r <= DIV_FIX;
               end else begin
                  state_r <= DIV_RUN;
               end
            end

            DIV_FIX: begin
               if (q_neg_r) begin
                  quot_r <= neg2c(q_work_r);
               end else begin
                  quot_r <= q_work_r;
               end
               if (r_neg_r) begin
                  rem_r <= neg2c(r_work_r);
               end else begin
                  rem_r <= r_work_r;
               end
               state_r <= DIV_DONE;
               done_r  <= 1'b1;
            end

            DIV_DONE: begin
               state_r <= DIV_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end

            default: begin
               state_r <= DIV_IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // stallreq must rise in the same cycle EX presents the divide, so the IDLE
   // term follows start combinationally; elsewhere it is a state decode.
   always_comb begin
      case (state_r)
         DIV_IDLE: stall_s = (start == DIV_START);
         DIV_PREP: stall_s = 1'b1;
         DIV_RUN:  stall_s = 1'b1;
         DIV_FIX:  stall_s = 1'b1;
         DIV_DONE: stall_s = DIV_STOP;
         default:  stall_s = 1'b0;
      endcase
   end

   assign stallreq = stall_s;
   assign busy     = busy_r;
   assign done     = done_r;
   assign quot     = quot_r;
   assign rem      = rem_r;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Scoreboard bench for div_ctrl: the stimulus process pushes the expected
// quotient/remainder and the cycle in which done must appear; a monitor pops
// and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] op_a = 32'h0000_0000;
   logic [31:0] op_b = 32'h0000_0000;
   logic        stallreq;
   logic        busy;
   logic        done;
   logic [31:0] quot;
   logic [31:0] rem;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   div_ctrl #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .flush     (flush),
      .op_a      (op_a),
      .op_b      (op_b),
      .stallreq  (stallreq),
      .busy      (busy),
      .done      (done),
      .quot      (quot),
      .rem       (rem)
   );

   always #5 clk = ~clk;

   // Cycle index: value seen between rising edges.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
               mon_e = sb_q.pop_front();
               chk("quot", quot, mon_e.q);
               chk("rem", rem, mon_e.r);
               chk("done_cycle", 32'(cyc), 32'(mon_e.due));
               chk("stallreq_at_done", {31'd0, stallreq}, 32'd0);
            end
         end
      end
   end

   // Issue one division, check stallreq each cycle until done, then IDLE.
   // poke drives a stray start with other operands mid-operation.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [31:0] eq, input logic [31:0] er, input int lat,
                         input bit poke);
      exp_t e;
      int   c0;
      bit   seen;
      @(negedge clk);
      start = 1'b1; signed_op = sg; op_a = a; op_b = b;
      c0 = cyc;
      e.q = eq; e.r = er; e.due = c0 + lat;
      sb_q.push_back(e);
      #1 chk("stall_on_start", {31'd0, stallreq}, 32'd1);
      @(negedge clk);
      start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; signed_op = ~sg;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            chk("stall_in_flight", {31'd0, stallreq}, 32'd1);
            chk("busy_in_flight", {31'd0, busy}, 32'd1);
            start = (poke && (cyc == c0 + 5)) ? 1'b1 : 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done (issued cycle %0d)", c0);
      end
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("stall_after_done", {31'd0, stallreq}, 32'd0);
   endtask

   initial begin
      int c0;
      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_quot", quot, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_stall", {31'd0, stallreq}, 32'd0);
      rst_n = 1'b1;

      // Directed vectors, expected values worked out by hand.
      run_op(32'd100,       32'd7,        1'b0, 32'd14,        32'd2,        35, 1'b0); // DIVU 100/7
      run_op(32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, 1'b1); // DIV -7/2, stray start
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,       35, 1'b0); // DIV overflow
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,        32'h8000_0000, 35, 1'b0); // DIVU 2^31/(2^32-1)
      run_op(32'd1234,      32'd0,        1'b0, 32'hFFFF_FFFF, 32'd1234,    3,  1'b0); // DIVU by zero
      run_op(32'hFFFF_FFF9, 32'd0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3, 1'b0); // DIV by zero, no sign fix
      run_op(32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,       35, 1'b0); // DIV 7/-2
      run_op(32'hFFFF_FFFF, 32'd1,        1'b0, 32'hFFFF_FFFF, 32'd0,       35, 1'b0); // DIVU max/1
      run_op(32'd5,         32'd9,        1'b0, 32'd0,         32'd5,       35, 1'b0); // DIVU small/large
      run_op(32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b1, 32'd4,        32'd0,       35, 1'b0); // DIV -8/-2

      // Flush in RUN step 10: back to IDLE, no done, previous result held.
      @(negedge clk);
      start = 1'b1; signed_op = 1'b0; op_a = 32'd100; op_b = 32'd7; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 12) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_stall", {31'd0, stallreq}, 32'd0);
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_quot_kept", quot, 32'd4);
      chk("flush_rem_kept", rem, 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_still_idle", {31'd0, busy}, 32'd0);

      // Flush wins over start in IDLE.
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_over_start", {31'd0, busy}, 32'd0);

      // Async reset in RUN step 20, then a fresh operation.
      start = 1'b1; signed_op = 1'b0; op_a = 32'd100; op_b = 32'd7; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 22) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_quot", quot, 32'd0);
      chk("arst_rem", rem, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_stall", {31'd0, stallreq}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd1000, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FEB3, 32'd1, 35, 1'b0); // DIV 1000/-3

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "time limit");
   end

endmodule : tb_div_ctrl
